// File: rtl/ordenador_burbuja.sv
// In-place ascending bubble sort over an external RAM with combinational read.
// Each compare reads a pair, and a swap writes it back over two cycles.
module ordenador_burbuja #(
  parameter int N  = 12,
  parameter int W  = 8,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [W-1:0]  Dato_s,
  output logic [AW-1:0] Dir,
  output logic [W-1:0]  Dato_e,
  output logic          EN,
  output logic          ocupado,
  output logic          listo
);

  // state   | meaning
  // IDLE    | waiting for start, listo holds last result
  // LEE_A   | Dir=i, capture word i
  // LEE_B   | Dir=i+1, capture word i+1
  // COMPARA | decide swap
  // ESC_A   | write word i
  // ESC_B   | write word i+1
  // SIG     | advance index or close the pass
  // FIN     | sort done, back to IDLE
  typedef enum logic [2:0] {
    IDLE, LEE_A, LEE_B, COMPARA, ESC_A, ESC_B, SIG, FIN
  } state_t;

  localparam int LW = (N > 1) ? $clog2(N) : 1;
  localparam logic [LW-1:0] LIM_MAX = LW'(N - 1);

  state_t        state_q, state_d;
  logic [LW-1:0] i_q, i_d;
  logic [LW-1:0] limite_q, limite_d;
  logic          cambio_q, cambio_d;
  logic [W-1:0]  reg_a_q, reg_a_d;
  logic [W-1:0]  reg_b_q, reg_b_d;
  logic [AW-1:0] dir_q, dir_d;
  logic [W-1:0]  dato_e_q, dato_e_d;
  logic          en_q, en_d;
  logic          ocupado_q, ocupado_d;
  logic          listo_q, listo_d;
  logic [LW-1:0] i_inc;

  function automatic logic [AW-1:0] to_dir(input logic [LW-1:0] v);
    return AW'(v);
  endfunction

  // i+1 never exceeds limite, so it always fits in LW bits
  assign i_inc = i_q + LW'(1);

  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    limite_d  = limite_q;
    cambio_d  = cambio_q;
    reg_a_d   = reg_a_q;
    reg_b_d   = reg_b_q;
    dir_d     = dir_q;
    dato_e_d  = dato_e_q;
    en_d      = 1'b0;
    ocupado_d = ocupado_q;
    listo_d   = listo_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          listo_d   = 1'b0;
          i_d       = '0;
          limite_d  = LIM_MAX;
          cambio_d  = 1'b0;
          ocupado_d = 1'b1;
          dir_d     = '0;
          if (N == 1) begin
            listo_d = 1'b1;
            state_d = FIN;
          end else begin
            state_d = LEE_A;
          end
        end
      end
      LEE_A: begin
        reg_a_d = Dato_s;
        dir_d   = to_dir(i_inc);
        state_d = LEE_B;
      end
      LEE_B: begin
        reg_b_d = Dato_s;
        state_d = COMPARA;
      end
      COMPARA: begin
        if (reg_a_q > reg_b_q) begin
          dir_d    = to_dir(i_q);
          dato_e_d = reg_b_q;
          en_d     = 1'b1;
          state_d  = ESC_A;
        end else begin
          state_d = SIG;
        end
      end
      ESC_A: begin
        dir_d    = to_dir(i_inc);
        dato_e_d = reg_a_q;
        en_d     = 1'b1;
        state_d  = ESC_B;
      end
      ESC_B: begin
        cambio_d = 1'b1;
        state_d  = SIG;
      end
      SIG: begin
        if (i_inc < limite_q) begin
          i_d     = i_inc;
          dir_d   = to_dir(i_inc);
          state_d = LEE_A;
        end else if (!cambio_q || limite_q == LW'(1)) begin
          // a swap-free pass means the remaining prefix is already ordered
          listo_d = 1'b1;
          state_d = FIN;
        end else begin
          limite_d = limite_q - LW'(1);
          i_d      = '0;
          cambio_d = 1'b0;
          dir_d    = '0;
          state_d  = LEE_A;
        end
      end
      FIN: begin
        ocupado_d = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      i_q       <= '0;
      limite_q  <= LIM_MAX;
      cambio_q  <= 1'b0;
      reg_a_q   <= '0;
      reg_b_q   <= '0;
      dir_q     <= '0;
      dato_e_q  <= '0;
      en_q      <= 1'b0;
      ocupado_q <= 1'b0;
      listo_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      limite_q  <= limite_d;
      cambio_q  <= cambio_d;
      reg_a_q   <= reg_a_d;
      reg_b_q   <= reg_b_d;
      dir_q     <= dir_d;
      dato_e_q  <= dato_e_d;
      en_q      <= en_d;
      ocupado_q <= ocupado_d;
      listo_q   <= listo_d;
    end
  end

  assign Dir     = dir_q;
  assign Dato_e  = dato_e_q;
  assign EN      = en_q;
  assign ocupado = ocupado_q;
  assign listo   = listo_q;

endmodule

// File: tb/tb_ordenador_burbuja.sv
// Directed bench for ordenador_burbuja: a 12-word sorter on a behavioural RAM
// plus a single-word instance.
module tb_ordenador_burbuja;
  localparam int N  = 12;
  localparam int W  = 8;
  localparam int AW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  logic [W-1:0]  dato_s_a, dato_e_a, dato_s_b, dato_e_b;
  logic [AW-1:0] dir_a, dir_b;
  logic en_a, en_b, ocup_a, ocup_b, listo_a, listo_b;

  logic [W-1:0] mem [N];
  logic [W-1:0] load_vals [N];
  logic         load_req = 1'b0;
  logic [W-1:0] mem_b = 8'd42;

  int tests = 0;
  int fails = 0;
  int en_cnt_a = 0;
  int en_cnt_b = 0;
  int dir_bad = 0;

  always #5 clk = ~clk;

  ordenador_burbuja #(.N(N), .W(W), .AW(AW)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .Dato_s(dato_s_a),
    .Dir(dir_a), .Dato_e(dato_e_a), .EN(en_a), .ocupado(ocup_a), .listo(listo_a)
  );

  ordenador_burbuja #(.N(1), .W(W), .AW(AW)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .Dato_s(dato_s_b),
    .Dir(dir_b), .Dato_e(dato_e_b), .EN(en_b), .ocupado(ocup_b), .listo(listo_b)
  );

  assign dato_s_a = (dir_a < AW'(N)) ? mem[dir_a[3:0]] : '0;
  assign dato_s_b = mem_b;

  always @(posedge clk) begin
    if (load_req) mem <= load_vals;
    else if (en_a && dir_a < AW'(N)) mem[dir_a[3:0]] <= dato_e_a;
    if (en_b) mem_b <= dato_e_b;
    if (en_a) en_cnt_a <= en_cnt_a + 1;
    if (en_b) en_cnt_b <= en_cnt_b + 1;
    if (!rst && dir_a > AW'(N - 1)) dir_bad <= dir_bad + 1;
  end

  task automatic load(input logic [W-1:0] v [N]);
    load_vals = v;
    load_req = 1'b1;
    @(posedge clk);
    #1 load_req = 1'b0;
  endtask

  // edges counts clock edges from the one sampling start (edge 1) to the one
  // after which listo is seen high
  task automatic run_sort(input int hold, input bit repulse, input int budget,
                          output int edges, output bit listo_cleared, output bit ocup_gap);
    int cnt;
    ocup_gap = 1'b0;
    start_a = 1'b1;
    @(posedge clk);
    cnt = 1;
    #1;
    listo_cleared = (listo_a === 1'b0);
    while (listo_a !== 1'b1 && cnt < budget) begin
      if (ocup_a !== 1'b1) ocup_gap = 1'b1;
      start_a = (cnt < hold) || (repulse && (cnt == 50 || cnt == 150));
      @(posedge clk);
      cnt++;
      #1;
    end
    start_a = 1'b0;
    edges = cnt;
  endtask

  task automatic test_reset();
    #2;
    tests++; if (dir_a !== 8'd0) begin fails++; $display("FAIL reset_dir got %0d want 0", dir_a); end
    tests++; if (dato_e_a !== 8'd0) begin fails++; $display("FAIL reset_dato_e got %0d want 0", dato_e_a); end
    tests++; if (en_a !== 1'b0) begin fails++; $display("FAIL reset_en got %b want 0", en_a); end
    tests++; if (ocup_a !== 1'b0) begin fails++; $display("FAIL reset_ocupado got %b want 0", ocup_a); end
    tests++; if (listo_a !== 1'b0) begin fails++; $display("FAIL reset_listo got %b want 0", listo_a); end
    tests++; if ({en_b, ocup_b, listo_b} !== 3'b000) begin fails++; $display("FAIL reset_n1 got %b want 000", {en_b, ocup_b, listo_b}); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    tests++; if (ocup_a !== 1'b0) begin fails++; $display("FAIL idle_ocupado got %b want 0", ocup_a); end
  endtask

  task automatic test_reverse();
    logic [W-1:0] v [N];
    logic [W-1:0] e [N];
    int edges, en0;
    bit lc, gap;
    v = '{90, 80, 70, 60, 50, 40, 30, 20, 10, 100, 101, 102};
    e = '{10, 20, 30, 40, 50, 60, 70, 80, 90, 100, 101, 102};
    load(v);
    en0 = en_cnt_a;
    run_sort(1, 1'b0, 600, edges, lc, gap);
    tests++; if (edges != 325) begin fails++; $display("FAIL t1_cycles got %0d want 325", edges); end
    tests++; if (listo_a !== 1'b1) begin fails++; $display("FAIL t1_listo got %b want 1", listo_a); end
    tests++; if (!lc) begin fails++; $display("FAIL t1_listo_clear got 1 want 0"); end
    tests++; if (gap) begin fails++; $display("FAIL t1_ocupado_gap got 0 want 1"); end
    tests++; if (en_cnt_a - en0 != 72) begin fails++; $display("FAIL t1_en_cycles got %0d want 72", en_cnt_a - en0); end
    for (int k = 0; k < N; k++) begin
      tests++; if (mem[k] !== e[k]) begin fails++; $display("FAIL t1_mem[%0d] got %0d want %0d", k, mem[k], e[k]); end
    end
    @(posedge clk);
    #1;
    tests++; if (ocup_a !== 1'b0 || listo_a !== 1'b1) begin fails++; $display("FAIL t1_after got ocupado=%b listo=%b want 0 1", ocup_a, listo_a); end
  endtask

  task automatic test_presorted();
    logic [W-1:0] v [N];
    int edges, en0;
    bit lc, gap;
    v = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12};
    load(v);
    en0 = en_cnt_a;
    run_sort(1, 1'b0, 200, edges, lc, gap);
    tests++; if (edges != 45) begin fails++; $display("FAIL t2_cycles got %0d want 45", edges); end
    tests++; if (en_cnt_a != en0) begin fails++; $display("FAIL t2_en_cycles got %0d want 0", en_cnt_a - en0); end
    tests++; if (mem[0] !== 8'd1 || mem[11] !== 8'd12) begin fails++; $display("FAIL t2_mem got %0d %0d want 1 12", mem[0], mem[11]); end
    @(posedge clk);
    #1;
    tests++; if (ocup_a !== 1'b0 || listo_a !== 1'b1) begin fails++; $display("FAIL t2_after got ocupado=%b listo=%b want 0 1", ocup_a, listo_a); end
  endtask

  task automatic test_equal();
    logic [W-1:0] v [N];
    int edges, en0;
    bit lc, gap;
    for (int k = 0; k < N; k++) v[k] = 8'd55;
    load(v);
    en0 = en_cnt_a;
    run_sort(1, 1'b0, 200, edges, lc, gap);
    tests++; if (edges != 45) begin fails++; $display("FAIL t3_cycles got %0d want 45", edges); end
    tests++; if (en_cnt_a != en0) begin fails++; $display("FAIL t3_en_cycles got %0d want 0", en_cnt_a - en0); end
    tests++; if (mem[6] !== 8'd55) begin fails++; $display("FAIL t3_mem got %0d want 55", mem[6]); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_abort();
    logic [W-1:0] v [N];
    logic [W-1:0] e [N];
    int cnt, n_en, edges;
    bit lc, gap;
    v = '{90, 80, 70, 60, 50, 40, 30, 20, 10, 100, 101, 102};
    e = '{10, 20, 30, 40, 50, 60, 70, 80, 90, 100, 101, 102};
    load(v);
    start_a = 1'b1;
    @(posedge clk);
    #1 start_a = 1'b0;
    cnt = 0;
    n_en = 0;
    // the 9th write-enable cycle is ESC_A of the fifth swap (pair 4/5)
    while (cnt < 400) begin
      if (en_a === 1'b1) begin
        n_en++;
        if (n_en == 9) break;
      end
      @(posedge clk);
      cnt++;
      #1;
    end
    tests++; if (en_a !== 1'b1 || dir_a !== 8'd4 || dato_e_a !== 8'd40) begin
      fails++; $display("FAIL t4_esc_a got en=%b dir=%0d dato=%0d want 1 4 40", en_a, dir_a, dato_e_a); end
    #1 rst = 1'b1;
    #1;
    tests++; if (en_a !== 1'b0 || ocup_a !== 1'b0 || listo_a !== 1'b0) begin
      fails++; $display("FAIL t4_async got en=%b ocupado=%b listo=%b want 0 0 0", en_a, ocup_a, listo_a); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    tests++; if (mem[0] !== 8'd80 || mem[4] !== 8'd90 || mem[5] !== 8'd40) begin
      fails++; $display("FAIL t4_partial got %0d %0d %0d want 80 90 40", mem[0], mem[4], mem[5]); end
    run_sort(1, 1'b0, 600, edges, lc, gap);
    tests++; if (listo_a !== 1'b1) begin fails++; $display("FAIL t4_listo got %b want 1", listo_a); end
    for (int k = 0; k < N; k++) begin
      tests++; if (mem[k] !== e[k]) begin fails++; $display("FAIL t4_mem[%0d] got %0d want %0d", k, mem[k], e[k]); end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_start_ignored();
    logic [W-1:0] v [N];
    logic [W-1:0] e [N];
    int edges, en0;
    bit lc, gap;
    v = '{90, 80, 70, 60, 50, 40, 30, 20, 10, 100, 101, 102};
    e = '{10, 20, 30, 40, 50, 60, 70, 80, 90, 100, 101, 102};
    load(v);
    en0 = en_cnt_a;
    run_sort(12, 1'b1, 600, edges, lc, gap);
    tests++; if (edges != 325) begin fails++; $display("FAIL t5_cycles got %0d want 325", edges); end
    tests++; if (en_cnt_a - en0 != 72) begin fails++; $display("FAIL t5_en_cycles got %0d want 72", en_cnt_a - en0); end
    tests++; if (gap) begin fails++; $display("FAIL t5_ocupado_gap got 0 want 1"); end
    for (int k = 0; k < N; k++) begin
      tests++; if (mem[k] !== e[k]) begin fails++; $display("FAIL t5_mem[%0d] got %0d want %0d", k, mem[k], e[k]); end
    end
    @(posedge clk);
    #1;
    tests++; if (ocup_a !== 1'b0 || listo_a !== 1'b1) begin fails++; $display("FAIL t5_after got ocupado=%b listo=%b want 0 1", ocup_a, listo_a); end
    en0 = en_cnt_a;
    run_sort(1, 1'b0, 200, edges, lc, gap);
    tests++; if (!lc) begin fails++; $display("FAIL t5_resort_listo_clear got 1 want 0"); end
    tests++; if (edges != 45) begin fails++; $display("FAIL t5_resort_cycles got %0d want 45", edges); end
    tests++; if (en_cnt_a != en0) begin fails++; $display("FAIL t5_resort_en got %0d want 0", en_cnt_a - en0); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    int en0;
    en0 = en_cnt_b;
    start_b = 1'b1;
    @(posedge clk);
    #1 start_b = 1'b0;
    tests++; if (ocup_b !== 1'b1 || listo_b !== 1'b1 || en_b !== 1'b0) begin
      fails++; $display("FAIL t6_fin got ocupado=%b listo=%b en=%b want 1 1 0", ocup_b, listo_b, en_b); end
    @(posedge clk);
    #1;
    tests++; if (ocup_b !== 1'b0 || listo_b !== 1'b1) begin
      fails++; $display("FAIL t6_idle got ocupado=%b listo=%b want 0 1", ocup_b, listo_b); end
    tests++; if (en_cnt_b != en0 || mem_b !== 8'd42 || dir_b !== 8'd0) begin
      fails++; $display("FAIL t6_nowrite got en=%0d mem=%0d dir=%0d want 0 42 0", en_cnt_b - en0, mem_b, dir_b); end
  endtask

  initial begin
    test_reset();
    test_reverse();
    test_presorted();
    test_equal();
    test_abort();
    test_start_ignored();
    test_single();
    tests++; if (dir_bad != 0) begin fails++; $display("FAIL dir_range got %0d out-of-range cycles want 0", dir_bad); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
